project_select_ctrl: RTL and testbench
======================================

PROJECT_SELECT_CTRL -- requirements
Module: project_select_ctrl

Interface
REQ-001 SHALL have parameter CFG_ADDRESS, default 32'h300FFFFC, the Wishbone byte address of the select register.
REQ-002 SHALL have parameter USER_PROJECTS, default 4, the number of selectable projects.
REQ-003 SHALL have parameter CFG_BITS, default 2, the select width, equal to clog2(USER_PROJECTS).
REQ-004 SHALL have parameter SWITCH_HOLD, default 8, the project-reset hold in cycles (range 1..255).
REQ-005 SHALL have parameter DEBOUNCE, default 4, the cycles a synchronized pad value must stay stable (range 1..255).
REQ-006 SHALL use one clock and a synchronous, active-high reset: wb_clk_i in 1 is the clock; wb_rst_i in 1 is the reset.
REQ-007 SHALL provide these Wishbone slave ports: wbs_stb_i in 1; wbs_cyc_i in 1; wbs_we_i in 1; wbs_sel_i in 4; wbs_dat_i in 32; wbs_adr_i in 32; wbs_ack_o out 1; wbs_dat_o out 32.
REQ-008 SHALL provide cfg_pad_i in CFG_BITS, the asynchronous top user IO pad bits.
REQ-009 SHALL provide configuration_o out CFG_BITS, the active project index that drives the downstream output muxes.
REQ-010 SHALL provide proj_clk_en_o out 1, the clock enable gating the project clock.
REQ-011 SHALL provide proj_rst_o out 1, the reset forced onto the projects.
REQ-012 SHALL provide cfg_hit_o out 1, combinational and high when cyc&stb&(adr==CFG_ADDRESS), so the wrapper can block forwarding of that access to projects.
REQ-013 SHALL provide switch_busy_o out 1, high whenever the FSM is not in RUN.

Function
REQ-014 SHALL pass cfg_pad_i through a 2-FF synchronizer, then a debounce counter; a changed synced value becomes pad_req only after DEBOUNCE consecutive equal cycles.
REQ-015 SHALL hold a register with fields sw_sel[CFG_BITS-1:0] and sw_mode (bit 8); target = sw_mode ? sw_sel : pad_req.
REQ-016 SHALL, on a write hit, update sw_sel when wbs_sel_i[0]=1 and sw_mode when wbs_sel_i[1]=1; the values SHALL affect target from the next cycle.
REQ-017 SHALL ignore a written sw_sel >= USER_PROJECTS (field unchanged), while still acking the write.
REQ-018 SHALL return, on a read hit: [CFG_BITS-1:0] configuration_o, [8] sw_mode, [16+CFG_BITS-1:16] target, [31] switch_busy_o, other bits 0; wbs_dat_o SHALL be 0 when not acking.
REQ-019 SHALL drive wbs_ack_o as a one-cycle pulse in the cycle after a hit, with no ack in the cycle after an ack; non-hit accesses SHALL never be acked.
REQ-020 SHALL implement FSM states RUN, RST_OLD, GATE, RST_NEW.
REQ-021 SHALL, in RUN, set clk_en=1 and rst=0; when target!=configuration_o and target<USER_PROJECTS, go to RST_OLD and load counter=SWITCH_HOLD.
REQ-022 SHALL, in RST_OLD, set clk_en=1 and rst=1, decrement the counter, and go to GATE on counter==1.
REQ-023 SHALL, in GATE, which lasts exactly 1 cycle, set clk_en=0 and rst=1, latch configuration_o<=target, and go to RST_NEW with counter=SWITCH_HOLD.
REQ-024 SHALL, in RST_NEW, set clk_en=1 and rst=1, and go to RUN on counter==1.
REQ-025 SHALL change configuration_o only in GATE.
REQ-026 SHALL ignore target changes during RST_OLD, GATE, and RST_NEW; target SHALL be re-compared on return to RUN, so a last-write-wins request is serviced immediately.
REQ-027 SHALL treat a target equal to configuration_o on return to RUN as no switch.
REQ-028 SHALL ignore pad_req while sw_mode=1 and sw_sel while sw_mode=0.

Reset
REQ-029 SHALL, while wb_rst_i=1, set configuration_o=0, sw_sel=0, sw_mode=0, wbs_ack_o=0, and wbs_dat_o=0; the synchronizer, pad_req, and debounce state SHALL reset to 0.
REQ-030 SHALL, while wb_rst_i=1, force the FSM to RST_NEW with counter=SWITCH_HOLD, so proj_rst_o=1 for SWITCH_HOLD cycles after release.
REQ-031 SHALL abandon any switch in progress when wb_rst_i is asserted mid-switch, with no partial configuration update.

Structure
REQ-032 SHALL place FSM state encoding, register bit offsets, and CFG_ADDRESS default in the shared package project_select_pkg.
REQ-033 SHALL implement the synchronizer and debounce as sub-module pad_debounce (parameter WIDTH, DEBOUNCE).

Verification
REQ-034 SHALL verify reset release: proj_rst_o=1 for exactly 8 cycles, then 0, with configuration_o=0 and switch_busy_o low at cycle 9.
REQ-035 SHALL verify a write of 0x102 to 0x300FFFFC with sel=4'b0011: ack 1 cycle later; rst held 8 cycles, clk_en=0 one cycle, configuration_o=2 in that cycle, rst held 8 more cycles.
REQ-036 SHALL verify, with sw_mode=0, a pad change 0->3 held 3 cycles then reverted: no switch; held 4+ cycles: switch to 3.
REQ-037 SHALL verify that writing sel 1 then sel 3 during RST_OLD completes the switch to 1, then immediately starts a switch to 3.
REQ-038 SHALL verify that a read during a switch returns bit31=1, the target in [17:16], and the old configuration in [1:0]; a non-hit address gives cfg_hit_o=0 and no ack.
REQ-039 SHALL verify that asserting wb_rst_i in GATE gives configuration_o=0, then a fresh 8-cycle RST_NEW.

Source files
------------

// File: rtl/project_select_pkg.sv
// Shared definitions for the project select controller: switch FSM
// encoding, select register field offsets and the default register address.
package project_select_pkg;

    localparam logic [31:0] CFG_ADDRESS_DEFAULT = 32'h300F_FFFC;

    // Select register layout (read and write share the low fields).
    localparam int CFG_LSB    = 0;   // sw_sel on write, configuration_o on read
    localparam int MODE_BIT   = 8;   // sw_mode
    localparam int TARGET_LSB = 16;  // current target (read only)
    localparam int BUSY_BIT   = 31;  // switch in progress (read only)

    // Width of the hold/debounce counters; both parameters are limited to 1..255.
    localparam int HOLD_W = 8;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_RST_OLD = 2'd1,
        ST_GATE    = 2'd2,
        ST_RST_NEW = 2'd3
    } switch_state_e;

endpackage

// File: rtl/project_select_ctrl_if.sv
// Wishbone slave bus carrying accesses to the project select register.
interface project_select_ctrl_if;

    logic        wbs_stb_i;
    logic        wbs_cyc_i;
    logic        wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_dat_i;
    logic [31:0] wbs_adr_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;

    modport master (
        output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i,
        input  wbs_ack_o, wbs_dat_o
    );

    modport slave (
        input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i,
        output wbs_ack_o, wbs_dat_o
    );

endinterface

// File: rtl/pad_debounce.sv
// Two-flop synchronizer followed by a stability filter: a new pad value is
// forwarded to pad_req only once it has been seen DEBOUNCE cycles in a row.
module pad_debounce #(
    parameter int WIDTH    = 2,
    parameter int DEBOUNCE = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] pad,
    output logic [WIDTH-1:0] pad_req
);

    localparam logic [7:0] CNT_MAX = 8'(DEBOUNCE);

    logic [WIDTH-1:0] sync_1;
    logic [WIDTH-1:0] sync_2;
    logic [WIDTH-1:0] last_val;
    logic [7:0]       stable_cnt;

    // Synchronize the pad, count how long the synced value has held, publish when stable.
    // NOTE: non-blocking assignments let every flop sample its pre-edge input; blocking ones would collapse the synchronizer into a single stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_1     <= '0;
            sync_2     <= '0;
            last_val   <= '0;
            stable_cnt <= '0;
            pad_req    <= '0;
        end else begin
            sync_1 <= pad;
            sync_2 <= sync_1;
            if (sync_2 != last_val) begin
                last_val   <= sync_2;
                stable_cnt <= 8'd1;
            end else if (stable_cnt != CNT_MAX) begin
                stable_cnt <= stable_cnt + 8'd1;
            end
            if (stable_cnt == CNT_MAX) begin
                pad_req <= last_val;
            end
        end
    end

endmodule

// File: rtl/project_select_ctrl.sv
// Project select controller: a Wishbone select register plus a debounced pad
// request choose the active user project; every change is wrapped in a
// reset / clock-gate / reset sequence so projects never see a glitchy switch.
module project_select_ctrl
    import project_select_pkg::*;
#(
    parameter logic [31:0] CFG_ADDRESS   = CFG_ADDRESS_DEFAULT,
    parameter int          USER_PROJECTS = 4,
    parameter int          CFG_BITS      = 2,
    parameter int          SWITCH_HOLD   = 8,
    parameter int          DEBOUNCE      = 4
) (
    input  logic                wb_clk_i,
    input  logic                wb_rst_i,
    project_select_ctrl_if.slave wbs,
    input  logic [CFG_BITS-1:0] cfg_pad_i,
    output logic [CFG_BITS-1:0] configuration_o,
    output logic                proj_clk_en_o,
    output logic                proj_rst_o,
    output logic                cfg_hit_o,
    output logic                switch_busy_o
);

    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(SWITCH_HOLD);
    localparam logic [31:0]       NUM_PROJ  = 32'(USER_PROJECTS);

    logic [CFG_BITS-1:0] pad_req;
    logic [CFG_BITS-1:0] sw_sel;
    logic                sw_mode;
    logic [CFG_BITS-1:0] target;
    logic [CFG_BITS-1:0] pending_cfg;
    logic [HOLD_W-1:0]   hold_cnt;
    switch_state_e       state;
    logic                access;
    logic [31:0]         rd_data;
    logic                unused_wb_bits;

    function automatic logic in_range(input logic [CFG_BITS-1:0] idx);
        return 32'(idx) < NUM_PROJ;
    endfunction

    pad_debounce #(
        .WIDTH    (CFG_BITS),
        .DEBOUNCE (DEBOUNCE)
    ) u_pad_debounce (
        .clk     (wb_clk_i),
        .rst     (wb_rst_i),
        .pad     (cfg_pad_i),
        .pad_req (pad_req)
    );

    // A hit stays asserted through the ack cycle; only its first cycle is an access.
    assign cfg_hit_o = wbs.wbs_cyc_i & wbs.wbs_stb_i & (wbs.wbs_adr_i == CFG_ADDRESS);
    assign access    = cfg_hit_o & ~wbs.wbs_ack_o;
    assign target    = sw_mode ? sw_sel : pad_req;

    // Only part of the write data and byte enables carry register fields.
    assign unused_wb_bits = ^{wbs.wbs_dat_i, wbs.wbs_sel_i[3:2]};

    // Assemble the read view of the select register.
    // NOTE: rd_data is given a full default first, so no branch can leave it unassigned and infer a latch.
    always_comb begin
        rd_data                          = '0;
        rd_data[CFG_LSB +: CFG_BITS]     = configuration_o;
        rd_data[MODE_BIT]                = sw_mode;
        rd_data[TARGET_LSB +: CFG_BITS]  = target;
        rd_data[BUSY_BIT]                = switch_busy_o;
    end

    // Wishbone register: single-cycle ack, read data only while acking, byte-lane field writes.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            wbs.wbs_ack_o <= 1'b0;
            wbs.wbs_dat_o <= '0;
            sw_sel        <= '0;
            sw_mode       <= 1'b0;
        end else begin
            wbs.wbs_ack_o <= access;
            wbs.wbs_dat_o <= (access && !wbs.wbs_we_i) ? rd_data : '0;
            if (access && wbs.wbs_we_i) begin
                // Out-of-range project numbers leave sw_sel untouched; the write is still acked.
                if (wbs.wbs_sel_i[0] && in_range(wbs.wbs_dat_i[CFG_LSB +: CFG_BITS])) begin
                    sw_sel <= wbs.wbs_dat_i[CFG_LSB +: CFG_BITS];
                end
                if (wbs.wbs_sel_i[1]) begin
                    sw_mode <= wbs.wbs_dat_i[MODE_BIT];
                end
            end
        end
    end

    // Switch sequencer: hold old project in reset, gate the clock for one cycle
    // while the mux select moves, then hold the new project in reset.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state           <= ST_RST_NEW;
            hold_cnt        <= HOLD_LOAD;
            configuration_o <= '0;
            pending_cfg     <= '0;
            proj_clk_en_o   <= 1'b1;
            proj_rst_o      <= 1'b1;
            switch_busy_o   <= 1'b1;
        end else begin
            case (state)
                ST_RUN: begin
                    // The target is captured here; later edits wait for the next return to RUN.
                    if (target != configuration_o && in_range(target)) begin
                        state         <= ST_RST_OLD;
                        hold_cnt      <= HOLD_LOAD;
                        pending_cfg   <= target;
                        proj_rst_o    <= 1'b1;
                        switch_busy_o <= 1'b1;
                    end
                end
                ST_RST_OLD: begin
                    if (hold_cnt == HOLD_W'(1)) begin
                        // Outputs are registered, so the new select becomes visible
                        // exactly in the gated cycle.
                        state           <= ST_GATE;
                        proj_clk_en_o   <= 1'b0;
                        configuration_o <= pending_cfg;
                    end else begin
                        hold_cnt <= hold_cnt - HOLD_W'(1);
                    end
                end
                ST_GATE: begin
                    state         <= ST_RST_NEW;
                    hold_cnt      <= HOLD_LOAD;
                    proj_clk_en_o <= 1'b1;
                end
                ST_RST_NEW: begin
                    if (hold_cnt == HOLD_W'(1)) begin
                        state         <= ST_RUN;
                        proj_rst_o    <= 1'b0;
                        switch_busy_o <= 1'b0;
                    end else begin
                        hold_cnt <= hold_cnt - HOLD_W'(1);
                    end
                end
                default: begin
                    state    <= ST_RST_NEW;
                    hold_cnt <= HOLD_LOAD;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_project_select_ctrl.sv
// Directed bench for project_select_ctrl: a register-access vector table plus
// hand-written sequences for reset release, switching, pad debounce and reset mid-switch.
module tb_project_select_ctrl;

    localparam logic [31:0] CFG_ADDR   = 32'h300F_FFFC;
    localparam logic [31:0] OTHER_ADDR = 32'h300F_FFF8;

    typedef struct {
        string       name;
        logic        we;
        logic        cyc;
        logic [31:0] adr;
        logic [3:0]  sel;
        logic [31:0] wdat;
        logic        exp_hit;
        logic        exp_ack;
        logic [31:0] exp_rdat;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] pad = 2'd0;
    logic [1:0] configuration;
    logic       clk_en;
    logic       proj_rst;
    logic       cfg_hit;
    logic       busy;

    int total = 0;
    int bad   = 0;

    vec_t vecs[13];

    project_select_ctrl_if wb ();

    project_select_ctrl dut (
        .wb_clk_i        (clk),
        .wb_rst_i        (rst),
        .wbs             (wb),
        .cfg_pad_i       (pad),
        .configuration_o (configuration),
        .proj_clk_en_o   (clk_en),
        .proj_rst_o      (proj_rst),
        .cfg_hit_o       (cfg_hit),
        .switch_busy_o   (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic bus_idle();
        wb.wbs_cyc_i = 1'b0;
        wb.wbs_stb_i = 1'b0;
        wb.wbs_we_i  = 1'b0;
        wb.wbs_sel_i = 4'h0;
        wb.wbs_dat_i = 32'h0;
        wb.wbs_adr_i = 32'h0;
    endtask

    function automatic vec_t mk(input string name, input logic we, input logic cyc,
                                input logic [31:0] adr, input logic [3:0] sel,
                                input logic [31:0] wdat, input logic exp_hit,
                                input logic exp_ack, input logic [31:0] exp_rdat);
        vec_t v;
        v.name = name; v.we = we; v.cyc = cyc; v.adr = adr; v.sel = sel;
        v.wdat = wdat; v.exp_hit = exp_hit; v.exp_ack = exp_ack; v.exp_rdat = exp_rdat;
        return v;
    endfunction

    // One bus access started at a negedge: hit, ack one cycle later, data, ack drop.
    task automatic bus_access(input vec_t v);
        wb.wbs_cyc_i = v.cyc;
        wb.wbs_stb_i = 1'b1;
        wb.wbs_we_i  = v.we;
        wb.wbs_adr_i = v.adr;
        wb.wbs_sel_i = v.sel;
        wb.wbs_dat_i = v.wdat;
        #1;
        check({v.name, " hit"}, 32'(cfg_hit), 32'(v.exp_hit));
        tick();
        check({v.name, " ack"}, 32'(wb.wbs_ack_o), 32'(v.exp_ack));
        check({v.name, " rdat"}, wb.wbs_dat_o, v.exp_rdat);
        bus_idle();
        tick();
        check({v.name, " ack_low"}, 32'(wb.wbs_ack_o), 32'd0);
        check({v.name, " dat_low"}, wb.wbs_dat_o, 32'd0);
    endtask

    task automatic wr(input string name, input logic [31:0] data, input logic [3:0] sel);
        bus_access(mk(name, 1'b1, 1'b1, CFG_ADDR, sel, data, 1'b1, 1'b1, 32'h0));
    endtask

    // Called at a negedge with reset asserted for at least one edge.
    task automatic reset_release_check(input string tag);
        check({tag, " rst_cfg"}, 32'(configuration), 32'd0);
        check({tag, " rst_ack"}, 32'(wb.wbs_ack_o), 32'd0);
        check({tag, " rst_dat"}, wb.wbs_dat_o, 32'd0);
        check({tag, " rst_busy"}, 32'(busy), 32'd1);
        rst = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            if (k > 1) tick();
            check($sformatf("%s proj_rst k=%0d", tag, k), 32'(proj_rst), (k <= 8) ? 32'd1 : 32'd0);
        end
        check({tag, " cfg_after"}, 32'(configuration), 32'd0);
        check({tag, " busy_after"}, 32'(busy), 32'd0);
        check({tag, " clk_en_after"}, 32'(clk_en), 32'd1);
    endtask

    task automatic wait_gate(input string name);
        int n = 0;
        while (clk_en !== 1'b0 && n < 40) begin
            tick();
            n++;
        end
        check({name, " gate_reached"}, 32'(n < 40), 32'd1);
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (busy !== 1'b0 && n < 60) begin
            tick();
            n++;
        end
        check({name, " idle_reached"}, 32'(n < 60), 32'd1);
    endtask

    // Measure a full switch starting from the first reset-old sample.
    task automatic observe_switch(input string name, input logic [1:0] old_cfg, input logic [1:0] new_cfg);
        int n_old = 0;
        int n_new = 0;
        int cfg_err = 0;
        while (proj_rst === 1'b1 && clk_en === 1'b1 && n_old < 40) begin
            if (configuration !== old_cfg) cfg_err++;
            n_old++;
            tick();
        end
        check({name, " old_hold"}, n_old, 32'd8);
        check({name, " old_cfg_kept"}, cfg_err, 32'd0);
        check({name, " gate_clk_en"}, 32'(clk_en), 32'd0);
        check({name, " gate_rst"}, 32'(proj_rst), 32'd1);
        check({name, " gate_cfg"}, 32'(configuration), 32'(new_cfg));
        tick();
        while (proj_rst === 1'b1 && clk_en === 1'b1 && n_new < 40) begin
            n_new++;
            tick();
        end
        check({name, " new_hold"}, n_new, 32'd8);
        check({name, " run_rst"}, 32'(proj_rst), 32'd0);
        check({name, " run_busy"}, 32'(busy), 32'd0);
        check({name, " run_cfg"}, 32'(configuration), 32'(new_cfg));
    endtask

    initial begin
        int n;
        int busy_seen;

        bus_idle();
        // Register-access vectors, applied from RUN with configuration 0 and pad 0.
        vecs[0]  = mk("rd_cfg",       1'b0, 1'b1, CFG_ADDR,   4'hF, 32'h0,   1'b1, 1'b1, 32'h0000_0000);
        vecs[1]  = mk("rd_other",     1'b0, 1'b1, OTHER_ADDR, 4'hF, 32'h0,   1'b0, 1'b0, 32'h0000_0000);
        vecs[2]  = mk("rd_no_cyc",    1'b0, 1'b0, CFG_ADDR,   4'hF, 32'h0,   1'b0, 1'b0, 32'h0000_0000);
        vecs[3]  = mk("wr_other",     1'b1, 1'b1, OTHER_ADDR, 4'h3, 32'h103, 1'b0, 1'b0, 32'h0000_0000);
        vecs[4]  = mk("rd_untouched", 1'b0, 1'b1, CFG_ADDR,   4'hF, 32'h0,   1'b1, 1'b1, 32'h0000_0000);
        vecs[5]  = mk("wr_mode1",     1'b1, 1'b1, CFG_ADDR,   4'h2, 32'h100, 1'b1, 1'b1, 32'h0000_0000);
        vecs[6]  = mk("rd_mode1",     1'b0, 1'b1, CFG_ADDR,   4'hF, 32'h0,   1'b1, 1'b1, 32'h0000_0100);
        vecs[7]  = mk("wr_no_lanes",  1'b1, 1'b1, CFG_ADDR,   4'h0, 32'h003, 1'b1, 1'b1, 32'h0000_0000);
        vecs[8]  = mk("rd_no_lanes",  1'b0, 1'b1, CFG_ADDR,   4'hF, 32'h0,   1'b1, 1'b1, 32'h0000_0100);
        vecs[9]  = mk("wr_mode0",     1'b1, 1'b1, CFG_ADDR,   4'h2, 32'h000, 1'b1, 1'b1, 32'h0000_0000);
        vecs[10] = mk("wr_sel3_pad",  1'b1, 1'b1, CFG_ADDR,   4'h1, 32'h003, 1'b1, 1'b1, 32'h0000_0000);
        vecs[11] = mk("rd_pad_tgt",   1'b0, 1'b1, CFG_ADDR,   4'hF, 32'h0,   1'b1, 1'b1, 32'h0000_0000);
        vecs[12] = mk("wr_sel0",      1'b1, 1'b1, CFG_ADDR,   4'h1, 32'h000, 1'b1, 1'b1, 32'h0000_0000);

        // Power-on reset and release.
        tick(); tick(); tick();
        reset_release_check("por");

        for (int i = 0; i < 13; i++) begin
            bus_access(vecs[i]);
            check({vecs[i].name, " no_switch"}, 32'(busy), 32'd0);
        end

        // Software switch 0 -> 2.
        wr("sw_to_2", 32'h102, 4'b0011);
        observe_switch("sw_to_2", 2'd0, 2'd2);

        // Last write wins: 1 is serviced, then 3 starts straight from RUN.
        wr("lww_1", 32'h101, 4'b0011);
        wr("lww_3", 32'h103, 4'b0001);
        wait_gate("lww_first");
        check("lww first_cfg", 32'(configuration), 32'd1);
        wait_idle("lww_first");
        check("lww run_cfg", 32'(configuration), 32'd1);
        check("lww run_rst", 32'(proj_rst), 32'd0);
        tick();
        check("lww restart_busy", 32'(busy), 32'd1);
        check("lww restart_rst", 32'(proj_rst), 32'd1);
        wait_gate("lww_second");
        check("lww second_cfg", 32'(configuration), 32'd3);
        wait_idle("lww_second");

        // Read during a switch 3 -> 1, and a non-hit access meanwhile.
        wr("busy_sw", 32'h001, 4'b0001);
        bus_access(mk("rd_busy", 1'b0, 1'b1, CFG_ADDR, 4'hF, 32'h0, 1'b1, 1'b1, 32'h8001_0103));
        bus_access(mk("rd_miss_busy", 1'b0, 1'b1, 32'h3000_0000, 4'hF, 32'h0, 1'b0, 1'b0, 32'h0));
        wait_idle("busy_sw");
        check("busy_sw cfg", 32'(configuration), 32'd1);

        // Back to pad control: pad_req is 0, so this switches to 0.
        wr("to_pad", 32'h000, 4'b0010);
        wait_idle("to_pad");
        check("to_pad cfg", 32'(configuration), 32'd0);

        // A 3-cycle pad pulse is filtered out.
        pad = 2'd3;
        tick(); tick(); tick();
        pad = 2'd0;
        busy_seen = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (busy === 1'b1) busy_seen++;
        end
        check("pad_short busy_cycles", busy_seen, 32'd0);
        check("pad_short cfg", 32'(configuration), 32'd0);

        // A held pad value is accepted.
        pad = 2'd3;
        n = 0;
        while (busy !== 1'b1 && n < 30) begin
            tick();
            n++;
        end
        check("pad_long started", 32'(n < 30), 32'd1);
        wait_idle("pad_long");
        check("pad_long cfg", 32'(configuration), 32'd3);

        // Reset asserted in the gated cycle of a 3 -> 1 switch.
        wr("gate_rst_sw", 32'h101, 4'b0011);
        pad = 2'd0;
        wait_gate("gate_rst");
        check("gate_rst gate_cfg", 32'(configuration), 32'd1);
        rst = 1'b1;
        tick();
        check("gate_rst cfg_cleared", 32'(configuration), 32'd0);
        check("gate_rst proj_rst", 32'(proj_rst), 32'd1);
        check("gate_rst clk_en", 32'(clk_en), 32'd1);
        tick();
        reset_release_check("gate_rst");
        bus_access(mk("rd_after_rst", 1'b0, 1'b1, CFG_ADDR, 4'hF, 32'h0, 1'b1, 1'b1, 32'h0));
        for (int i = 0; i < 10; i++) tick();
        check("after_rst busy", 32'(busy), 32'd0);
        check("after_rst cfg", 32'(configuration), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
